button_unit: RTL and testbench

BUTTON_UNIT -- requirements
Module: button_unit

---
 rtl/button_unit_pkg.sv | 19 +
 rtl/button_unit_btn_debounce.sv | 57 +++++
 rtl/button_unit.sv | 116 +++++++++++
 tb/tb_button_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/button_unit_pkg.sv
// Shared definitions for the button/calibration front end and the LED status logic.
// Holds the press-FSM encoding and the counter sizing helpers.
package button_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } btn_state_t;

    localparam int DEBOUNCE_TICKS_DEF   = 50;
    localparam int LONG_PRESS_TICKS_DEF = 5000;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_unit_btn_debounce.sv
// Two-flop synchronizer plus stability-counter debouncer for a raw push-button.
// o_rise/o_fall are registered one-cycle pulses aligned with the o_level change.
module btn_debounce
    import button_unit_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int             CW   = cnt_width(DEBOUNCE_TICKS);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_TICKS - 1);

    logic          r_meta;
    logic          r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // Accept the new level on the DEBOUNCE_TICKS-th consecutive differing sample.
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync;
                r_rise  <= r_sync;
                r_fall  <= ~r_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/button_unit.sv
// Calibration push-button: debounced short press toggles calibration mode,
// long press or loss of ADC init forces it off.
module button_unit
    import button_unit_pkg::*;
#(
    parameter int DEBOUNCE_TICKS   = DEBOUNCE_TICKS_DEF,
    parameter int LONG_PRESS_TICKS = LONG_PRESS_TICKS_DEF
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btn_calib,
    input  logic i_adc_init_done,
    output logic o_calib_enabled,
    output logic o_calib_start,
    output logic o_calib_abort
);

    localparam int             HW      = cnt_width(LONG_PRESS_TICKS);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_PRESS_TICKS);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_PRESS_TICKS - 1);

    logic w_level;
    logic w_rise;
    logic w_fall;

    btn_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_raw   (i_btn_calib),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    btn_state_t    r_state, w_state_nxt;
    logic [HW-1:0] r_hold,  w_hold_nxt;
    logic          r_en,    w_en_nxt;
    logic          r_start, w_start_nxt;
    logic          r_abort, w_abort_nxt;
    logic          w_short_evt;
    logic          w_long_evt;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_en    <= 1'b0;
            r_start <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_en    <= w_en_nxt;
            r_start <= w_start_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_short_evt = 1'b0;
        w_long_evt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_hold_nxt = '0;
                if (w_rise) w_state_nxt = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (r_hold != HOLD_MAX) w_hold_nxt = r_hold + 1'b1;
                // A release seen on the same edge the hold limit is reached still counts as short.
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                    w_short_evt = 1'b1;
                end else if (r_hold >= HOLD_LAST) begin
                    w_state_nxt = ST_LONG_HELD;
                    w_long_evt  = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (w_fall) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        w_en_nxt    = r_en;
        w_start_nxt = 1'b0;
        w_abort_nxt = 1'b0;
        // Losing ADC init overrides any button event in the same cycle.
        if (!i_adc_init_done) begin
            if (r_en) begin
                w_en_nxt    = 1'b0;
                w_abort_nxt = 1'b1;
            end
        end else if (w_short_evt) begin
            w_en_nxt    = ~r_en;
            w_start_nxt = ~r_en;
            w_abort_nxt = r_en;
        end else if (w_long_evt && r_en) begin
            w_en_nxt    = 1'b0;
            w_abort_nxt = 1'b1;
        end
    end

    assign o_calib_enabled = r_en;
    assign o_calib_start   = r_start;
    assign o_calib_abort   = r_abort;

endmodule

// File: tb/tb_button_unit.sv
// Directed bench for button_unit with DEBOUNCE_TICKS=4, LONG_PRESS_TICKS=20.
module tb_button_unit;

    localparam int DT = 4;
    localparam int LP = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic raw   = 1'b0;
    logic adc   = 1'b1;
    logic en, st, ab;

    always #5 clk = ~clk;

    button_unit #(
        .DEBOUNCE_TICKS   (DT),
        .LONG_PRESS_TICKS (LP)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_btn_calib     (raw),
        .i_adc_init_done (adc),
        .o_calib_enabled (en),
        .o_calib_start   (st),
        .o_calib_abort   (ab)
    );

    int n_chk   = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_abort = 0;
    int n_both  = 0;

    // Pulse high-cycle counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (st) n_start++;
        if (ab) n_abort++;
        if (st && ab) n_both++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int hold);
        raw = 1'b1;
        tick(hold);
        raw = 1'b0;
    endtask

    typedef struct {
        string name;
        int    hold;
        bit    adc;
        bit    exp_en;
        int    exp_start;
        int    exp_abort;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int s0, a0;

        vecs[0] = '{"short_disable",   10, 1'b1, 1'b0, 0, 1};
        vecs[1] = '{"long_while_off",  30, 1'b1, 1'b0, 0, 0};
        vecs[2] = '{"short_enable",    10, 1'b1, 1'b1, 1, 0};
        vecs[3] = '{"long_abort",      30, 1'b1, 1'b0, 0, 1};
        vecs[4] = '{"adc_low_press",   10, 1'b0, 1'b0, 0, 0};
        vecs[5] = '{"glitch_3",         3, 1'b1, 1'b0, 0, 0};
        vecs[6] = '{"min_press_4",      4, 1'b1, 1'b1, 1, 0};
        vecs[7] = '{"adc_drop_abort",  10, 1'b0, 1'b0, 0, 1};
        vecs[8] = '{"reenable",        10, 1'b1, 1'b1, 1, 0};
        vecs[9] = '{"disable_again",   10, 1'b1, 1'b0, 0, 1};

        // Reset state
        tick(3);
        check("reset_en",    int'(en), 0);
        check("reset_start", int'(st), 0);
        check("reset_abort", int'(ab), 0);
        rst_n = 1'b1;
        tick(2);

        // Clean 10-cycle press: start pulse exactly 7 edges after the raw fall
        a0 = n_abort;
        press(10);
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check($sformatf("start_timing_%0d", k), int'(st), (k == 7) ? 1 : 0);
        end
        check("first_enable", int'(en), 1);
        check("first_no_abort", n_abort - a0, 0);
        tick(4);

        for (int i = 0; i < 10; i++) begin
            adc = vecs[i].adc;
            s0  = n_start;
            a0  = n_abort;
            press(vecs[i].hold);
            tick(14);
            check({vecs[i].name, "_en"},    int'(en),    int'(vecs[i].exp_en));
            check({vecs[i].name, "_start"}, n_start - s0, vecs[i].exp_start);
            check({vecs[i].name, "_abort"}, n_abort - a0, vecs[i].exp_abort);
        end

        // Train of 2-cycle pulses with 2-cycle gaps never passes the debouncer
        adc = 1'b1;
        s0  = n_start;
        a0  = n_abort;
        for (int i = 0; i < 5; i++) begin
            raw = 1'b1;
            tick(2);
            raw = 1'b0;
            tick(2);
        end
        tick(12);
        check("glitch_train_en",    int'(en), 0);
        check("glitch_train_start", n_start - s0, 0);
        check("glitch_train_abort", n_abort - a0, 0);

        // ADC init drops while the short-press release is being acted on
        press(10);
        tick(14);
        check("pre_drop_en", int'(en), 1);
        s0 = n_start;
        a0 = n_abort;
        press(10);
        tick(6);
        adc = 1'b0;
        tick(8);
        check("drop_release_en",    int'(en), 0);
        check("drop_release_start", n_start - s0, 0);
        check("drop_release_abort", n_abort - a0, 1);
        adc = 1'b1;
        tick(4);

        // Reset mid-press while enabled; button let go 2 cycles after reset release
        press(10);
        tick(14);
        check("pre_reset_en", int'(en), 1);
        raw = 1'b1;
        tick(8);
        rst_n = 1'b0;
        #1;
        check("rst_async_en",    int'(en), 0);
        check("rst_async_start", int'(st), 0);
        check("rst_async_abort", int'(ab), 0);
        tick(3);
        rst_n = 1'b1;
        s0 = n_start;
        a0 = n_abort;
        tick(2);
        raw = 1'b0;
        tick(15);
        check("post_reset_en",    int'(en), 0);
        check("post_reset_start", n_start - s0, 0);
        check("post_reset_abort", n_abort - a0, 0);

        // A full press after reset works normally again
        s0 = n_start;
        press(10);
        tick(14);
        check("recover_en",    int'(en), 1);
        check("recover_start", n_start - s0, 1);

        check("start_abort_overlap", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
